// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone classic-cycle initiator that moves a block of consecutive words
// between local valid/ready streams and a Wishbone responder. Each word is one single-beat
// transfer; wb_cyc_o is held high for the whole burst. A beat that sees no ack for TIMEOUT_CYC
// stb-high cycles aborts the burst.
//
// Ports:
//   wb_clk_i, rst                         clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_we,
//   cmd_addr, cmd_len                     command: direction, start word address, words-1
//   wdata_valid/wdata_ready, wdata        write-data stream into the master
//   rdata_valid/rdata_ready, rdata        read-data stream out of the master
//   wb_cyc_o, wb_stb_o, wb_we_o,
//   wb_adr_o, wb_dat_o, wb_sel_o          Wishbone initiator outputs
//   wb_dat_i, wb_ack_i                    Wishbone responder data and acknowledge
//   busy, done, err                       status: not idle, completion pulse, abort pulse
module wb_burst_master #(
  parameter int unsigned ADDR_WD     = 8,
  parameter int unsigned DATA_WD     = 32,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                 wb_clk_i,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADDR_WD-1:0]   cmd_addr,
  input  logic [ADDR_WD-1:0]   cmd_len,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [DATA_WD-1:0]   wdata,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [DATA_WD-1:0]   rdata,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [ADDR_WD-1:0]   wb_adr_o,
  output logic [DATA_WD-1:0]   wb_dat_o,
  output logic [DATA_WD/8-1:0] wb_sel_o,
  input  logic [DATA_WD-1:0]   wb_dat_i,
  input  logic                 wb_ack_i,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned SelWd = DATA_WD / 8;
  localparam logic [7:0] TmoMax = 8'(TIMEOUT_CYC);
  localparam logic [ADDR_WD-1:0] AdrOne = {{(ADDR_WD-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StWdat, StReq, StRdout} state_e;

  state_e             r_state;
  logic               r_we;
  logic [ADDR_WD-1:0] r_adr;
  logic [ADDR_WD-1:0] r_rem;
  logic [DATA_WD-1:0] r_dat_o;
  logic [DATA_WD-1:0] r_rdata;
  logic [7:0]         r_tmo;
  logic               r_done;
  logic               r_err;
  logic               w_advance;

  // Beat accepted on this edge: write acked, or read word taken by the consumer.
  assign w_advance = ((r_state == StReq) && wb_ack_i && r_we) ||
                     ((r_state == StRdout) && rdata_ready);

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_rem   <= '0;
      r_dat_o <= '0;
      r_rdata <= '0;
      r_tmo   <= 8'd1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // Outside REQ the timeout count is parked at 1, so each beat starts counting from 1.
      if (r_state != StReq) r_tmo <= 8'd1;

      unique case (r_state)
        StIdle: begin
          if (cmd_valid) begin
            r_adr   <= cmd_addr;
            r_rem   <= cmd_len;
            r_we    <= cmd_we;
            r_state <= cmd_we ? StWdat : StReq;
          end
        end
        StWdat: begin
          if (wdata_valid) begin
            r_dat_o <= wdata;
            r_state <= StReq;
          end
        end
        StReq: begin
          if (wb_ack_i) begin
            if (!r_we) begin
              r_rdata <= wb_dat_i;
              r_state <= StRdout;
            end
          end else if (r_tmo == TmoMax) begin
            // Abort: remaining words are dropped and no more wdata is taken.
            r_err   <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        StRdout: ;
        default: r_state <= StIdle;
      endcase

      if (w_advance) begin
        if (r_rem == '0) begin
          r_done  <= 1'b1;
          r_state <= StIdle;
        end else begin
          r_adr   <= r_adr + AdrOne;
          r_rem   <= r_rem - AdrOne;
          r_state <= r_we ? StWdat : StReq;
        end
      end
    end
  end

  // Leaving REQ always passes through WDAT, RDOUT or IDLE, so stb drops after every ack.
  assign cmd_ready   = (r_state == StIdle);
  assign busy        = (r_state != StIdle);
  assign wb_cyc_o    = (r_state != StIdle);
  assign wb_stb_o    = (r_state == StReq);
  assign wdata_ready = (r_state == StWdat);
  assign rdata_valid = (r_state == StRdout);
  assign wb_sel_o    = {SelWd{wb_stb_o}};
  assign wb_we_o     = r_we;
  assign wb_adr_o    = r_adr;
  assign wb_dat_o    = r_dat_o;
  assign rdata       = r_rdata;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;

  logic        wb_clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = '0;
  logic        rdata_valid;
  logic        rdata_ready = 1'b0;
  logic [31:0] rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        busy, done, err;

  logic        no_ack = 1'b0;
  logic [31:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_burst_master #(
    .ADDR_WD    (8),
    .DATA_WD    (32),
    .TIMEOUT_CYC(15)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .rdata      (rdata),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Registered-ack SRAM responder.
  always @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      wb_ack_i <= 1'b0;
      wb_dat_i <= '0;
    end else begin
      wb_ack_i <= wb_cyc_o & wb_stb_o & ~wb_ack_i & ~no_ack;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && wb_we_o) mem[wb_adr_o] <= wb_dat_o;
      wb_dat_i <= mem[wb_adr_o];
    end
  end

  typedef struct {
    string       name;
    bit          we;
    logic [7:0]  addr;
    logic [7:0]  len;
    logic [31:0] base;
    int          stall_word;
    bit          no_ack;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
    chk({tag, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
    chk({tag, "_we"}, {31'd0, wb_we_o}, 32'd0);
    chk({tag, "_adr"}, {24'd0, wb_adr_o}, 32'd0);
    chk({tag, "_dat_o"}, wb_dat_o, 32'd0);
    chk({tag, "_sel"}, {28'd0, wb_sel_o}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, rdata_valid}, 32'd0);
    chk({tag, "_wready"}, {31'd0, wdata_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic run_burst(input vec_t v);
    int beat, word, cyc_n, first_rv, stb_cycles, n_done, n_abort, stall, wacc, cyc_gap;
    bit stalled, prev_ack, prev_stb, finished;
    logic [31:0] held;
    logic [7:0] ea;
    beat = 0; word = 0; cyc_n = 0; first_rv = 0; stb_cycles = 0; n_done = 0; n_abort = 0;
    stall = 0; wacc = 0; cyc_gap = 0; stalled = 0; prev_ack = 0; prev_stb = 0; finished = 0;
    held = '0;
    no_ack = v.no_ack;
    @(negedge wb_clk_i);
    chk({v.name, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_len = v.len;
    wdata = v.base; wdata_valid = 1'b1; rdata_ready = 1'b1;
    @(posedge wb_clk_i);
    #1 cmd_valid = 1'b0;
    while (cyc_n < 200 && !finished) begin
      @(negedge wb_clk_i);
      cyc_n++;
      if (wb_stb_o) stb_cycles++;
      if (prev_ack) chk({v.name, "_stb_low_after_ack"}, {31'd0, wb_stb_o}, 32'd0);
      if (wb_stb_o && !prev_stb) begin
        ea = v.addr + 8'(beat);
        chk({v.name, "_adr"}, {24'd0, wb_adr_o}, {24'd0, ea});
        chk({v.name, "_sel"}, {28'd0, wb_sel_o}, 32'hF);
        if (v.we) chk({v.name, "_dat_o"}, wb_dat_o, v.base + 32'(beat));
        beat++;
      end
      if (!wb_cyc_o && !done && !err) cyc_gap++;
      if (done) n_done++;
      if (err) n_abort++;
      if (done || err) begin
        finished = 1;
        chk({v.name, "_end_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
        chk({v.name, "_end_stb"}, {31'd0, wb_stb_o}, 32'd0);
        chk({v.name, "_end_idle"}, {31'd0, cmd_ready}, 32'd1);
        chk({v.name, "_end_wready"}, {31'd0, wdata_ready}, 32'd0);
      end
      // wdata is held through the next edge; advance it once the current word is taken.
      wdata = v.base + 32'(wacc);
      if (wdata_ready) wacc++;
      if (rdata_valid) begin
        if (first_rv == 0) first_rv = cyc_n;
        if (stall > 0) begin
          chk({v.name, "_held_rdata"}, rdata, held);
          chk({v.name, "_stall_stb"}, {31'd0, wb_stb_o}, 32'd0);
          stall--;
          if (stall == 0) rdata_ready = 1'b1;
        end else if (word == v.stall_word && !stalled) begin
          stalled = 1;
          held = rdata;
          rdata_ready = 1'b0;
          stall = 5;
        end
        if (rdata_ready) begin
          chk({v.name, "_rdata"}, rdata, v.base + 32'(word));
          word++;
        end
      end
      prev_ack = wb_ack_i;
      prev_stb = wb_stb_o;
    end
    chk({v.name, "_finished"}, {31'd0, finished}, 32'd1);
    if (v.no_ack) begin
      chk({v.name, "_stb_cycles"}, 32'(stb_cycles), 32'd15);
      chk({v.name, "_err_pulses"}, 32'(n_abort), 32'd1);
      chk({v.name, "_done_pulses"}, 32'(n_done), 32'd0);
    end else begin
      chk({v.name, "_beats"}, 32'(beat), 32'(v.len) + 32'd1);
      chk({v.name, "_done_pulses"}, 32'(n_done), 32'd1);
      chk({v.name, "_err_pulses"}, 32'(n_abort), 32'd0);
      chk({v.name, "_cyc_gap"}, 32'(cyc_gap), 32'd0);
      if (!v.we) begin
        chk({v.name, "_first_rvalid"}, 32'(first_rv), 32'd3);
        chk({v.name, "_words"}, 32'(word), 32'(v.len) + 32'd1);
      end
    end
    @(negedge wb_clk_i);
    chk({v.name, "_done_one_cycle"}, {30'd0, done, err}, 32'd0);
    wdata_valid = 1'b0;
    rdata_ready = 1'b0;
    no_ack = 1'b0;
  endtask

  initial begin
    vec_t vecs[8];
    int k;
    vecs[0] = '{"wr_burst",  1'b1, 8'h10, 8'd3, 32'hA0, -1, 1'b0};
    vecs[1] = '{"rd_burst",  1'b0, 8'h10, 8'd3, 32'hA0, -1, 1'b0};
    vecs[2] = '{"rd_stall",  1'b0, 8'h10, 8'd3, 32'hA0,  1, 1'b0};
    vecs[3] = '{"wr_wrap",   1'b1, 8'hFE, 8'd2, 32'hB0, -1, 1'b0};
    vecs[4] = '{"rd_wrap",   1'b0, 8'hFE, 8'd2, 32'hB0, -1, 1'b0};
    vecs[5] = '{"timeout",   1'b1, 8'h20, 8'd0, 32'hEE, -1, 1'b1};
    vecs[6] = '{"wr_after",  1'b1, 8'h30, 8'd0, 32'hC5, -1, 1'b0};
    vecs[7] = '{"rd_after",  1'b0, 8'h30, 8'd0, 32'hC5, -1, 1'b0};

    // Reset values while reset is held.
    #3 chk_reset_vals("in_reset");
    @(negedge wb_clk_i);
    rst = 1'b0;
    @(negedge wb_clk_i);
    chk_reset_vals("after_reset");

    foreach (vecs[i]) run_burst(vecs[i]);

    // Reset asserted during RDOUT of the second of four words.
    @(negedge wb_clk_i);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h10; cmd_len = 8'd3; rdata_ready = 1'b0;
    @(posedge wb_clk_i);
    #1 cmd_valid = 1'b0;
    k = 0;
    while (!rdata_valid && k < 50) begin @(negedge wb_clk_i); k++; end
    chk("rst_mid_word1_valid", {31'd0, rdata_valid}, 32'd1);
    rdata_ready = 1'b1;
    @(posedge wb_clk_i);
    #1 rdata_ready = 1'b0;
    k = 0;
    while (!rdata_valid && k < 50) begin @(negedge wb_clk_i); k++; end
    chk("rst_mid_word2_valid", {31'd0, rdata_valid}, 32'd1);
    chk("rst_mid_word2_data", rdata, 32'hA1);
    chk("rst_mid_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(negedge wb_clk_i);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge wb_clk_i);
      chk("rst_mid_no_done", {31'd0, done}, 32'd0);
      chk("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone classic-cycle initiator that moves a block of consecutive 32-bit words between local valid/ready streams and a Wishbone responder such as the SRAM wishbone wrapper. A command supplies start address, length and direction. The block issues one single-beat transfer per word, holding `wb_cyc_o` for the whole burst, and aborts on a per-beat ack timeout. It sits between the secure-memory control logic and the SRAM wishbone slave port.

## Interface
- `ADDR_WD`, default 8: word address width; also the width of the length field.
- `DATA_WD`, default 32: data width. Must be a multiple of 8.
- `TIMEOUT_CYC`, default 15: maximum number of stb-high cycles without ack before abort. Range 1..255.
- `wb_clk_i` in 1: the only clock. All logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_we` in 1: direction. 1 = write to slave, 0 = read from slave.
- `cmd_addr` in ADDR_WD: start word address.
- `cmd_len` in ADDR_WD: word count minus 1, so 0 means 1 word.
- `wdata_valid` in 1, `wdata_ready` out 1, `wdata` in DATA_WD: write-data stream.
- `rdata_valid` out 1, `rdata_ready` in 1, `rdata` out DATA_WD: read-data stream.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone master controls.
- `wb_adr_o` out ADDR_WD: Wishbone address.
- `wb_dat_o` out DATA_WD: Wishbone write data.
- `wb_sel_o` out DATA_WD/8: byte enables. Constant all-ones while stb is high, 0 otherwise.
- `wb_dat_i` in DATA_WD, `wb_ack_i` in 1: slave read data and acknowledge.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the burst completes.
- `err` out 1: one-cycle pulse on timeout abort.

## Operation
- States: IDLE, WDAT, REQ, RDOUT.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid`: latch addr into `wb_adr_o`, latch len into the remaining-word counter `rem`, latch we.
  - Next state is WDAT if we = 1, REQ if we = 0. `wb_cyc_o` rises together with the state change.
- **WDAT**
  - `wdata_ready` = 1 and `wb_cyc_o` = 1.
  - On `wdata_valid`: register `wdata` into `wb_dat_o` and go to REQ.
- **REQ**
  - `wb_cyc_o` = 1, `wb_stb_o` = 1, `wb_we_o` = latched we.
  - Timeout counter starts at 1 in the first REQ cycle of each beat.
  - On `wb_ack_i`, read: capture `wb_dat_i` into `rdata` and go to RDOUT.
  - On `wb_ack_i`, write: take the ADVANCE step.
  - No ack while counter = TIMEOUT_CYC: pulse `err`, clear cyc/stb, return to IDLE. Remaining words are discarded and no further wdata is consumed.
  - An ack in that same cycle wins over the timeout.
- **RDOUT**
  - `rdata_valid` = 1, `wb_cyc_o` = 1, `wb_stb_o` = 0.
  - On `rdata_ready`: take the ADVANCE step.
- **ADVANCE** (not a state; a registered decision on the accepting edge)
  - If `rem` = 0: pulse `done` next cycle, clear `wb_cyc_o`, go to IDLE.
  - Otherwise: `wb_adr_o` += 1 modulo 2^ADDR_WD, `rem` -= 1, go to WDAT (write) or REQ (read).
- `wb_stb_o` is always low for at least one cycle after each ack. This prevents a registered-ack slave from double-acking.
- `wb_ack_i` is ignored outside REQ.
- `cmd_valid` is ignored outside IDLE.
- `rdata` holds its value until the next capture.

## Timing
- Reset values:
  - state IDLE, so `cmd_ready` = 1 during and after reset.
  - All other outputs 0: `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `wb_adr_o`, `wb_dat_o`, `wb_sel_o`, `rdata`, `rdata_valid`, `wdata_ready`, `busy`, `done`, `err`.
- Reset asserted mid-burst: outputs go to reset values immediately and asynchronously. `wb_cyc_o` drops without waiting for ack.
- Read beat with registered-ack slave and `rdata_ready` tied high:
  - Cmd accepted at edge 0.
  - stb high in cycle 1; ack in cycle 2.
  - `rdata_valid` in cycle 3.
  - Next stb in cycle 4, giving 3 cycles per word.
- Write beat with `wdata_valid` tied high:
  - WDAT in cycle 1.
  - stb in cycle 2; ack in cycle 3.
  - WDAT again in cycle 4, giving 3 cycles per word.
- `done` and `err` assert in the cycle after the final or abort edge, together with `wb_cyc_o` = 0 and IDLE. A new command can be accepted in that same cycle.
- `busy` = (state != IDLE).

## Test plan
- **Write burst:** cmd we = 1, addr 0x10, len 3; wdata 0xA0..0xA3 with valid always high; registered-ack SRAM model.
  - Required: 4 stb pulses at adr 0x10..0x13 with those data and sel 0xF.
  - Required: `wb_cyc_o` high continuously throughout; `done` pulses once.
- **Read burst:** cmd we = 0, addr 0x10, len 3.
  - Required: `rdata` 0xA0..0xA3 in order.
  - Required: first `rdata_valid` 3 cycles after cmd acceptance; never two acks for one stb.
- **Read backpressure:** `rdata_ready` low for 5 cycles on word 1.
  - Required: `rdata_valid` and `rdata` held stable; stb stays low; no data lost.
- **Address wrap:** read addr 0xFE, len 2.
  - Required: `wb_adr_o` sequence 0xFE, 0xFF, 0x00, then `done`.
- **Timeout:** slave never acks; write len 0.
  - Required: stb high exactly 15 cycles, then `err` pulse, cyc and stb low, IDLE.
  - Required: the next command is accepted normally.
- **Reset mid-burst:** assert `rst` during RDOUT of word 2 of 4.
  - Required: all outputs at reset values immediately; `cmd_ready` = 1 after reset release; no `done` pulse.
